instr_mem_arbiter: RTL and testbench
====================================

// Module: instr_mem_arbiter
// PURPOSE
//  Shares the single-port instruction RAM between two requesters: the core instruction-fetch port (IF),
//  read-only, normally high priority, and the debug/program-loader port (DBG), read/write.
//  Sits between both masters and the RAM and drives its en/addr/wdata/we/be.
//  The RAM has 1-cycle read latency. A bounded starvation counter guarantees DBG progress
//  while IF fetches continuously.
// PARAMETERS
//  ADDR_WIDTH    8   byte-address width of the RAM port
//  DATA_WIDTH    32  data width; be width = DATA_WIDTH/8 (=4)
//  STARVE_LIMIT  4   consecutive DBG losses before DBG is forced to win (>=1)
// PORTS
//  clk            in   1             system clock, rising edge
//  rst_i          in   1             asynchronous reset, active-high
//  if_req_i       in   1             IF read request
//  if_addr_i      in   ADDR_WIDTH    IF byte address
//  if_gnt_o       out  1             IF request accepted this cycle
//  if_rvalid_o    out  1             IF read data valid
//  if_rdata_o     out  DATA_WIDTH    IF read data
//  dbg_req_i      in   1             DBG request
//  dbg_we_i       in   1             DBG write (1) / read (0)
//  dbg_addr_i     in   ADDR_WIDTH    DBG byte address
//  dbg_wdata_i    in   DATA_WIDTH    DBG write data
//  dbg_be_i       in   DATA_WIDTH/8  DBG byte enables
//  dbg_gnt_o      out  1             DBG request accepted this cycle
//  dbg_rvalid_o   out  1             DBG response valid (read data or write ack)
//  dbg_rdata_o    out  DATA_WIDTH    DBG read data
//  ram_en_o       out  1             RAM enable
//  ram_addr_o     out  ADDR_WIDTH    RAM byte address
//  ram_wdata_o    out  DATA_WIDTH    RAM write data
//  ram_we_o       out  1             RAM write enable
//  ram_be_o       out  DATA_WIDTH/8  RAM byte enables
//  ram_rdata_i    in   DATA_WIDTH    RAM read data, valid the cycle after ram_en_o
// BEHAVIOUR
//  - Handshake: requester holds req and its signals stable until gnt. gnt is combinational, same cycle.
//    At most one gnt per cycle. rvalid rises exactly 1 cycle after the matching gnt, for 1 cycle.
//  - Arbitration: only one requester -> it wins. Both requesting -> IF wins unless starve_cnt==STARVE_LIMIT,
//    in which case DBG wins.
//  - starve_cnt (width $clog2(STARVE_LIMIT+1)), registered:
//    +1 when dbg_req_i && if_gnt_o; cleared when dbg_gnt_o or !dbg_req_i; never exceeds STARVE_LIMIT.
//  - RAM drive, combinational from the winner:
//    ram_en_o = if_gnt_o | dbg_gnt_o; ram_addr_o = winner addr, 0 when idle.
//    ram_we_o = dbg_gnt_o & dbg_we_i; ram_wdata_o/ram_be_o = DBG values when ram_we_o, else 0.
//  - Response routing: registers resp_if, resp_dbg = previous cycle's if_gnt_o, dbg_gnt_o.
//    if_rvalid_o=resp_if, dbg_rvalid_o=resp_dbg.
//    if_rdata_o = dbg_rdata_o = ram_rdata_i, meaningful only under the respective rvalid.
//  - DBG writes also get dbg_rvalid_o one cycle after gnt (write ack); dbg_rdata_o is don't-care then.
//  - Back-to-back: a new gnt may coincide with the previous rvalid (full throughput, 1 access/cycle).
//  - Address is passed unmodified; word selection (drop low bits) is done by the RAM.
//  - Reset (rst_i=1, async): resp_if=resp_dbg=0, starve_cnt=0.
//    if_gnt_o=dbg_gnt_o=ram_en_o=ram_we_o=0 while rst_i is high, regardless of requests.
//    A response pending at reset assertion is dropped (no rvalid after release).
//    First grant possible in the first cycle with rst_i low.
// TESTING
//  1. IF only, addr 0x00,0x04,0x08 back-to-back ->
//     if_gnt 3 consecutive cycles, if_rvalid cycles+1..+3 with RAM words 0..2; dbg outputs stay 0.
//  2. DBG write addr 0x10, wdata 0xDEADBEEF, be 4'b0101, IF idle ->
//     ram_we=1, ram_be=0101, dbg_rvalid next cycle; a DBG read of 0x10 returns 0x00AD00EF over prior 0.
//  3. IF and DBG requesting continuously, STARVE_LIMIT=4 ->
//     grant pattern IF,IF,IF,IF,DBG repeating; starve_cnt never >4.
//  4. Both request, DBG drops req after 2 losses, re-requests ->
//     starve_cnt clears to 0; forced DBG win only after 4 fresh losses.
//  5. rst_i asserted the cycle after an IF gnt ->
//     no if_rvalid; all gnt/ram_en 0 during reset; starve_cnt 0; IF granted first cycle after release.

Source files
------------

// File: rtl/instr_mem_arbiter.sv
// Two-master arbiter for a single-port instruction RAM with 1-cycle read latency.
// IF normally wins; a saturating starvation counter forces a DBG win after STARVE_LIMIT losses.
module instr_mem_arbiter #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst_i,
    input  logic                    if_req_i,
    input  logic [ADDR_WIDTH-1:0]   if_addr_i,
    output logic                    if_gnt_o,
    output logic                    if_rvalid_o,
    output logic [DATA_WIDTH-1:0]   if_rdata_o,
    input  logic                    dbg_req_i,
    input  logic                    dbg_we_i,
    input  logic [ADDR_WIDTH-1:0]   dbg_addr_i,
    input  logic [DATA_WIDTH-1:0]   dbg_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] dbg_be_i,
    output logic                    dbg_gnt_o,
    output logic                    dbg_rvalid_o,
    output logic [DATA_WIDTH-1:0]   dbg_rdata_o,
    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int CNT_WIDTH = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STARVE_LIMIT);

    logic [CNT_WIDTH-1:0] r_starve_cnt;
    logic                 r_resp_if;
    logic                 r_resp_dbg;
    logic                 w_force_dbg;
    logic                 w_if_gnt;
    logic                 w_dbg_gnt;
    logic                 w_ram_we;

    // Grants are suppressed for the whole time reset is asserted, not just at the edge.
    assign w_force_dbg = (r_starve_cnt == CNT_MAX);
    assign w_if_gnt    = !rst_i && if_req_i && !(dbg_req_i && w_force_dbg);
    assign w_dbg_gnt   = !rst_i && dbg_req_i && (!if_req_i || w_force_dbg);
    assign w_ram_we    = w_dbg_gnt && dbg_we_i;

    assign if_gnt_o    = w_if_gnt;
    assign dbg_gnt_o   = w_dbg_gnt;

    always_comb begin
        ram_addr_o = '0;
        if (w_if_gnt) begin
            ram_addr_o = if_addr_i;
        end else if (w_dbg_gnt) begin
            ram_addr_o = dbg_addr_i;
        end
    end

    assign ram_en_o    = w_if_gnt | w_dbg_gnt;
    assign ram_we_o    = w_ram_we;
    assign ram_wdata_o = w_ram_we ? dbg_wdata_i : '0;
    assign ram_be_o    = w_ram_we ? dbg_be_i : BE_WIDTH'(0);

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_starve_cnt <= '0;
            r_resp_if    <= 1'b0;
            r_resp_dbg   <= 1'b0;
        end else begin
            r_resp_if  <= w_if_gnt;
            r_resp_dbg <= w_dbg_gnt;
            if (w_dbg_gnt || !dbg_req_i) begin
                r_starve_cnt <= '0;
            end else if (w_if_gnt && (r_starve_cnt != CNT_MAX)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

    assign if_rvalid_o  = r_resp_if;
    assign dbg_rvalid_o = r_resp_dbg;
    assign if_rdata_o   = ram_rdata_i;
    assign dbg_rdata_o  = ram_rdata_i;

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Scoreboard bench for instr_mem_arbiter: a behavioural RAM answers the DUT, expected
// read data is queued at grant time and compared when the matching rvalid appears.
module tb_instr_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int NW = 1 << (AW - 2);

    logic          clk = 1'b0;
    logic          rst_i;
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic          if_gnt_o;
    logic          if_rvalid_o;
    logic [DW-1:0] if_rdata_o;
    logic          dbg_req_i;
    logic          dbg_we_i;
    logic [AW-1:0] dbg_addr_i;
    logic [DW-1:0] dbg_wdata_i;
    logic [BW-1:0] dbg_be_i;
    logic          dbg_gnt_o;
    logic          dbg_rvalid_o;
    logic [DW-1:0] dbg_rdata_o;
    logic          ram_en_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_wdata_o;
    logic          ram_we_o;
    logic [BW-1:0] ram_be_o;
    logic [DW-1:0] ram_rdata_i;

    always #5 clk = ~clk;

    instr_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
        .dbg_wdata_i(dbg_wdata_i), .dbg_be_i(dbg_be_i), .dbg_gnt_o(dbg_gnt_o),
        .dbg_rvalid_o(dbg_rvalid_o), .dbg_rdata_o(dbg_rdata_o),
        .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
        .ram_we_o(ram_we_o), .ram_be_o(ram_be_o), .ram_rdata_i(ram_rdata_i)
    );

    // Behavioural RAM (written only through the DUT) and the bench's reference contents.
    logic [DW-1:0] ram_mem [NW];
    logic [DW-1:0] ref_mem [NW];

    always @(posedge clk) begin
        if (ram_en_o) begin
            if (ram_we_o) begin
                for (int b = 0; b < BW; b++) begin
                    if (ram_be_o[b]) ram_mem[ram_addr_o[AW-1:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
                end
            end
            ram_rdata_i <= ram_mem[ram_addr_o[AW-1:2]];
        end
    end

    typedef struct packed {
        logic          chk;
        logic [DW-1:0] data;
    } exp_t;

    exp_t if_q[$];
    exp_t dbg_q[$];
    int   n_total = 0;
    int   n_bad   = 0;
    logic exp_if_rv  = 1'b0;
    logic exp_dbg_rv = 1'b0;

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, check the combinational grant/RAM side and the
    // registered responses at the falling edge, then advance to just past the next rising edge.
    task automatic step(input logic rst, input logic ir, input logic [AW-1:0] ia,
                        input logic dr, input logic dw, input logic [AW-1:0] da,
                        input logic [DW-1:0] wd, input logic [BW-1:0] be,
                        input logic eig, input logic edg, input string tag);
        logic [AW-1:0] e_addr;
        logic          e_we;
        exp_t          e;
        rst_i = rst; if_req_i = ir; if_addr_i = ia;
        dbg_req_i = dr; dbg_we_i = dw; dbg_addr_i = da; dbg_wdata_i = wd; dbg_be_i = be;
        e_addr = eig ? ia : (edg ? da : '0);
        e_we   = edg && dw;
        @(negedge clk);
        check({tag, ".if_gnt"},   DW'(if_gnt_o),    DW'(eig));
        check({tag, ".dbg_gnt"},  DW'(dbg_gnt_o),   DW'(edg));
        check({tag, ".ram_en"},   DW'(ram_en_o),    DW'(eig | edg));
        check({tag, ".ram_we"},   DW'(ram_we_o),    DW'(e_we));
        check({tag, ".ram_addr"}, DW'(ram_addr_o),  DW'(e_addr));
        check({tag, ".ram_wdata"}, ram_wdata_o,     e_we ? wd : '0);
        check({tag, ".ram_be"},   DW'(ram_be_o),    e_we ? DW'(be) : '0);
        if (rst) begin
            exp_if_rv  = 1'b0;
            exp_dbg_rv = 1'b0;
            if_q.delete();
            dbg_q.delete();
        end
        check({tag, ".if_rvalid"},  DW'(if_rvalid_o),  DW'(exp_if_rv));
        check({tag, ".dbg_rvalid"}, DW'(dbg_rvalid_o), DW'(exp_dbg_rv));
        if (if_rvalid_o) begin
            if (if_q.size() == 0) check({tag, ".if_unexpected"}, DW'(1), DW'(0));
            else begin
                e = if_q.pop_front();
                if (e.chk) check({tag, ".if_rdata"}, if_rdata_o, e.data);
            end
        end
        if (dbg_rvalid_o) begin
            if (dbg_q.size() == 0) check({tag, ".dbg_unexpected"}, DW'(1), DW'(0));
            else begin
                e = dbg_q.pop_front();
                if (e.chk) check({tag, ".dbg_rdata"}, dbg_rdata_o, e.data);
            end
        end
        exp_if_rv  = eig;
        exp_dbg_rv = edg;
        if (eig) if_q.push_back('{chk: 1'b1, data: ref_mem[ia[AW-1:2]]});
        if (edg) begin
            if (dw) begin
                for (int b = 0; b < BW; b++) begin
                    if (be[b]) ref_mem[da[AW-1:2]][8*b +: 8] = wd[8*b +: 8];
                end
                dbg_q.push_back('{chk: 1'b0, data: '0});
            end else begin
                dbg_q.push_back('{chk: 1'b1, data: ref_mem[da[AW-1:2]]});
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int w = 0; w < NW; w++) begin
            ram_mem[w] = (w == 4) ? '0 : (32'h1000_0000 | DW'(w));
            ref_mem[w] = (w == 4) ? '0 : (32'h1000_0000 | DW'(w));
        end
        ram_rdata_i = '0;
        rst_i = 1'b1; if_req_i = 1'b0; if_addr_i = '0;
        dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0; dbg_be_i = '0;
        @(posedge clk);
        #1;

        // Reset held with both masters requesting: no grants, no RAM activity.
        step(1, 1, 8'h00, 1, 1, 8'h10, 32'hFFFF_FFFF, 4'hF, 0, 0, "rst0");
        step(1, 1, 8'h00, 1, 0, 8'h10, '0, '0, 0, 0, "rst1");

        // IF only, three back-to-back fetches.
        step(0, 1, 8'h00, 0, 0, 8'h00, '0, '0, 1, 0, "t1a");
        step(0, 1, 8'h04, 0, 0, 8'h00, '0, '0, 1, 0, "t1b");
        step(0, 1, 8'h08, 0, 0, 8'h00, '0, '0, 1, 0, "t1c");
        step(0, 0, 8'h00, 0, 0, 8'h00, '0, '0, 0, 0, "t1d");

        // DBG partial write then read-back of the same word.
        step(0, 0, 8'h00, 1, 1, 8'h10, 32'hDEAD_BEEF, 4'b0101, 0, 1, "t2w");
        step(0, 0, 8'h00, 0, 0, 8'h00, '0, '0, 0, 0, "t2ack");
        step(0, 0, 8'h00, 1, 0, 8'h10, '0, '0, 0, 1, "t2r");
        step(0, 0, 8'h00, 0, 0, 8'h00, '0, '0, 0, 0, "t2rd");
        check("t2.ref_word", ref_mem[4], 32'h00AD_00EF);

        // Both requesting continuously: IF,IF,IF,IF,DBG repeating.
        for (int i = 0; i < 10; i++) begin
            step(0, 1, AW'(8'h40 + 4 * i), 1, 0, 8'h20, '0, '0,
                 (i % 5) != 4, (i % 5) == 4, $sformatf("t3_%0d", i));
        end
        step(0, 0, 8'h00, 0, 0, 8'h00, '0, '0, 0, 0, "t3end");

        // DBG drops after two losses; the count restarts so four fresh losses are needed.
        step(0, 1, 8'h80, 1, 0, 8'h24, '0, '0, 1, 0, "t4a");
        step(0, 1, 8'h84, 1, 0, 8'h24, '0, '0, 1, 0, "t4b");
        step(0, 1, 8'h88, 0, 0, 8'h00, '0, '0, 1, 0, "t4drop");
        for (int i = 0; i < 5; i++) begin
            step(0, 1, AW'(8'h90 + 4 * i), 1, 0, 8'h28, '0, '0,
                 i != 4, i == 4, $sformatf("t4_%0d", i));
        end
        step(0, 0, 8'h00, 0, 0, 8'h00, '0, '0, 0, 0, "t4end");

        // Reset right after an IF grant: response dropped, starvation count cleared.
        step(0, 1, 8'hA0, 1, 0, 8'h2C, '0, '0, 1, 0, "t5a");
        step(0, 1, 8'hA4, 1, 0, 8'h2C, '0, '0, 1, 0, "t5b");
        step(1, 1, 8'hA8, 1, 0, 8'h2C, '0, '0, 0, 0, "t5rst");
        step(1, 1, 8'hA8, 1, 0, 8'h2C, '0, '0, 0, 0, "t5rst2");
        for (int i = 0; i < 5; i++) begin
            step(0, 1, AW'(8'hB0 + 4 * i), 1, 0, 8'h2C, '0, '0,
                 i != 4, i == 4, $sformatf("t5_%0d", i));
        end
        step(0, 0, 8'h00, 0, 0, 8'h00, '0, '0, 0, 0, "t5end");
        step(0, 0, 8'h00, 0, 0, 8'h00, '0, '0, 0, 0, "idle");

        check("final.if_q_empty",  DW'(if_q.size()),  '0);
        check("final.dbg_q_empty", DW'(dbg_q.size()), '0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
